// File: rtl/attn_token_serializer.sv
// -----------------------------------------------------------------------------
// attn_token_serializer
//
// Output-side reader for the attention pipeline. A single start pulse launches
// one job: after PIPE_LAT edges the packed token matrix is captured into an
// internal buffer, then streamed one Q8.8 word per valid/ready handshake in
// row-major order with row/column tags and last flags.
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   synchronous active-high reset
//   start       in   single-cycle launch pulse (Q/K/V presented this cycle)
//   mat_in      in   packed pipeline output, element (i,j) at word i*TOKEN_DIM+j
//   busy        out  high while waiting for the pipeline or streaming
//   m_valid     out  m_data holds a valid word
//   m_ready     in   consumer accepts the current word
//   m_data      out  current word (bit-exact copy of the captured element)
//   m_row       out  row index i of the current word
//   m_col       out  column index j of the current word
//   m_row_last  out  current word is the last column of its row
//   m_last      out  current word is the final word of the matrix
//   drop_err    out  sticky: a start arrived while a job was in flight
// -----------------------------------------------------------------------------
module attn_token_serializer #(
  parameter int  DATA_WIDTH = 16,
  parameter int  TOKEN_DIM  = 4,
  parameter int  TOKEN_NUM  = 8,
  parameter int  PIPE_LAT   = 3,
  localparam int ROW_W      = (TOKEN_NUM > 1) ? $clog2(TOKEN_NUM) : 1,
  localparam int COL_W      = (TOKEN_DIM > 1) ? $clog2(TOKEN_DIM) : 1
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      start,
  input  logic [DATA_WIDTH*TOKEN_DIM*TOKEN_NUM-1:0] mat_in,
  output logic                                      busy,
  output logic                                      m_valid,
  input  logic                                      m_ready,
  output logic [DATA_WIDTH-1:0]                     m_data,
  output logic [ROW_W-1:0]                          m_row,
  output logic [COL_W-1:0]                          m_col,
  output logic                                      m_row_last,
  output logic                                      m_last,
  output logic                                      drop_err
);

  localparam int WORDS = TOKEN_NUM * TOKEN_DIM;
  localparam int K_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int LAT_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(PIPE_LAT - 1);
  localparam logic [COL_W-1:0] COL_MAX  = COL_W'(TOKEN_DIM - 1);
  localparam logic [K_W-1:0]   K_MAX    = K_W'(WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_STREAM = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [LAT_W-1:0]      r_lat;
  logic [DATA_WIDTH-1:0] r_buf [WORDS];
  logic [DATA_WIDTH-1:0] w_words [WORDS];

  logic                  r_busy;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic [ROW_W-1:0]      r_row;
  logic [COL_W-1:0]      r_col;
  logic [K_W-1:0]        r_k;
  logic                  r_row_last;
  logic                  r_last;
  logic                  r_drop;

  logic                  w_load_lat;
  logic                  w_capture;
  logic                  w_drop;
  logic                  w_xfer;
  logic                  w_final;
  logic [K_W-1:0]        w_k_inc;
  logic                  w_col_wrap;
  logic [COL_W-1:0]      w_col_inc;
  logic [ROW_W-1:0]      w_row_inc;

  // Unpack the wide pipeline bus into an array of words, word k = i*TOKEN_DIM+j.
  genvar gi;
  generate
    for (gi = 0; gi < WORDS; gi++) begin : g_unpack
      assign w_words[gi] = mat_in[DATA_WIDTH*gi +: DATA_WIDTH];
    end
  endgenerate

  assign w_xfer  = r_valid & m_ready;
  assign w_final = w_xfer & r_last;

  // Row/column advance kept as separate counters so no divider is needed.
  assign w_k_inc    = r_k + K_W'(1);
  assign w_col_wrap = (r_col == COL_MAX);
  assign w_col_inc  = w_col_wrap ? '0 : (r_col + COL_W'(1));
  assign w_row_inc  = w_col_wrap ? (r_row + ROW_W'(1)) : r_row;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and control strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_load_lat   = 1'b0;
    w_capture    = 1'b0;
    w_drop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_WAIT;
          w_load_lat   = 1'b1;
        end
      end
      S_WAIT: begin
        if (start) begin
          w_drop = 1'b1;
        end
        if (r_lat == '0) begin
          w_capture    = 1'b1;
          w_state_next = S_STREAM;
        end
      end
      S_STREAM: begin
        if (w_final) begin
          // A start coinciding with the final transfer chains the next job.
          if (start) begin
            w_state_next = S_WAIT;
            w_load_lat   = 1'b1;
          end else begin
            w_state_next = S_IDLE;
          end
        end else if (start) begin
          w_drop = 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: latency counter, capture buffer and registered stream outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lat      <= '0;
      r_busy     <= 1'b0;
      r_valid    <= 1'b0;
      r_data     <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_k        <= '0;
      r_row_last <= 1'b0;
      r_last     <= 1'b0;
      r_drop     <= 1'b0;
      for (int i = 0; i < WORDS; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      if (w_load_lat) begin
        r_lat <= LAT_INIT;
      end else if ((r_state == S_WAIT) && (r_lat != '0)) begin
        r_lat <= r_lat - LAT_W'(1);
      end

      if (w_drop) begin
        r_drop <= 1'b1;
      end

      r_busy <= (w_state_next != S_IDLE);

      if (w_capture) begin
        for (int i = 0; i < WORDS; i++) begin
          r_buf[i] <= w_words[i];
        end
        // Word 0 comes straight from the bus since the buffer is being
        // written on this same edge.
        r_valid    <= 1'b1;
        r_data     <= w_words[0];
        r_row      <= '0;
        r_col      <= '0;
        r_k        <= '0;
        r_row_last <= (TOKEN_DIM == 1);
        r_last     <= (WORDS == 1);
      end else if (w_xfer) begin
        if (r_last) begin
          r_valid    <= 1'b0;
          r_data     <= '0;
          r_row      <= '0;
          r_col      <= '0;
          r_k        <= '0;
          r_row_last <= 1'b0;
          r_last     <= 1'b0;
        end else begin
          r_k        <= w_k_inc;
          r_data     <= r_buf[w_k_inc];
          r_col      <= w_col_inc;
          r_row      <= w_row_inc;
          r_row_last <= (w_col_inc == COL_MAX);
          r_last     <= (w_k_inc == K_MAX);
        end
      end
    end
  end

  assign busy       = r_busy;
  assign m_valid    = r_valid;
  assign m_data     = r_data;
  assign m_row      = r_row;
  assign m_col      = r_col;
  assign m_row_last = r_row_last;
  assign m_last     = r_last;
  assign drop_err   = r_drop;

endmodule

// File: tb/tb_attn_token_serializer.sv
// -----------------------------------------------------------------------------
// tb_attn_token_serializer
//
// Self-checking bench for attn_token_serializer with default parameters.
// Every expected word is pushed to a scoreboard when its job is launched and
// popped by a monitor when the DUT transfers it. Inputs are driven 2 ns after
// the rising edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_attn_token_serializer;

  localparam int DW = 16;
  localparam int TD = 4;
  localparam int TN = 8;
  localparam int PL = 3;
  localparam int NW = TD * TN;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [2:0]    row;
    logic [1:0]    col;
    logic          rl;
    logic          last;
  } exp_t;

  typedef struct {
    string         name;
    logic [DW-1:0] base;
    logic [DW-1:0] step;
    int            rmode;
    int            exp_lat;
    int            exp_xfers;
  } vec_t;

  logic              clk;
  logic              rst;
  logic              start;
  logic [DW*NW-1:0]  mat_in;
  logic              busy;
  logic              m_valid;
  logic              m_ready;
  logic [DW-1:0]     m_data;
  logic [2:0]        m_row;
  logic [1:0]        m_col;
  logic              m_row_last;
  logic              m_last;
  logic              drop_err;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   job_xfers = 0;
  int   last_xfer_cyc = 0;
  int   rmode = 0;
  int   ridx = 0;
  logic rpat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [DW-1:0] expw [NW];
  exp_t sb [$];
  logic prev_stall = 1'b0;
  exp_t prev_obs;

  attn_token_serializer #(
    .DATA_WIDTH (DW),
    .TOKEN_DIM  (TD),
    .TOKEN_NUM  (TN),
    .PIPE_LAT   (PL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mat_in     (mat_in),
    .busy       (busy),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_row      (m_row),
    .m_col      (m_col),
    .m_row_last (m_row_last),
    .m_last     (m_last),
    .drop_err   (drop_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Consumer ready: always 1, or the repeating 1,0,0,1,0,1 pattern.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (rmode == 0) begin
        m_ready = 1'b1;
      end else begin
        m_ready = rpat[ridx];
        ridx    = (ridx + 1) % 6;
      end
    end
  end

  // Monitor: stall stability and scoreboard comparison of every transfer.
  always @(negedge clk) begin
    exp_t obs;
    exp_t e;
    obs = {m_data, m_row, m_col, m_row_last, m_last};
    if (prev_stall) begin
      chk("hold_stable", {40'd0, m_valid, obs}, {40'd0, 1'b1, prev_obs});
    end
    if (!rst && m_valid && m_ready) begin
      job_xfers++;
      last_xfer_cyc = cyc;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word actual=%h required=none", obs);
      end else begin
        e = sb.pop_front();
        chk($sformatf("word_r%0d_c%0d", e.row, e.col), 64'(obs), 64'(e));
        $display("xfer data=%h row=%0d col=%0d row_last=%0b last=%0b", m_data, m_row, m_col,
                 m_row_last, m_last);
      end
    end
    prev_stall = !rst && m_valid && !m_ready;
    prev_obs   = obs;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load_pattern(input logic [DW-1:0] base, input logic [DW-1:0] step);
    for (int k = 0; k < NW; k++) begin
      expw[k] = base + step * DW'(k);
      mat_in[DW*k +: DW] = expw[k];
    end
  endtask

  task automatic push_expected();
    for (int k = 0; k < NW; k++) begin
      sb.push_back({expw[k], 3'(k / TD), 2'(k % TD), (k % TD) == TD - 1, k == NW - 1});
    end
  endtask

  // Pushes the expected stream, pulses start, returns the start cycle and
  // leaves the caller at the falling edge of the following cycle.
  task automatic start_job(output int c0);
    push_expected();
    job_xfers = 0;
    start = 1'b1;
    c0 = cyc;
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic wait_valid(input int c0, input string nm);
    int n;
    n = 0;
    while (!m_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_first_valid_cyc"}, 64'(cyc), 64'(c0 + PL + 1));
  endtask

  task automatic wait_idle(input string nm, input int exp_xfers);
    int n;
    n = 0;
    while ((busy || sb.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_busy_fall_cyc"}, 64'(cyc), 64'(last_xfer_cyc + 1));
    chk({nm, "_xfers"}, 64'(job_xfers), 64'(exp_xfers));
    chk({nm, "_sb_left"}, 64'(sb.size()), 64'd0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk(nm, {38'd0, busy, m_valid, m_data, m_row, m_col, m_row_last, m_last, drop_err}, 64'd0);
  endtask

  initial begin
    vec_t vecs [3];
    int   c0;
    int   c1;
    int   n;
    logic any_valid;

    vecs[0] = '{name: "basic",  base: 16'h0040, step: 16'h0100, rmode: 0, exp_lat: PL + 1, exp_xfers: NW};
    vecs[1] = '{name: "backpr", base: 16'h1234, step: 16'h0111, rmode: 1, exp_lat: PL + 1, exp_xfers: NW};
    vecs[2] = '{name: "wrap",   base: 16'hFF00, step: 16'h0003, rmode: 0, exp_lat: PL + 1, exp_xfers: NW};

    rst    = 1'b1;
    start  = 1'b0;
    mat_in = '0;
    repeat (3) tick();
    @(negedge clk);
    chk_all_zero("reset_state");
    tick();
    rst = 1'b0;
    tick();

    // Table-driven jobs.
    for (int i = 0; i < 3; i++) begin
      rmode = vecs[i].rmode;
      ridx  = 0;
      tick();
      load_pattern(vecs[i].base, vecs[i].step);
      start_job(c0);
      n = 0;
      while (!m_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk({vecs[i].name, "_first_valid_lat"}, 64'(cyc - c0), 64'(vecs[i].exp_lat));
      wait_idle(vecs[i].name, vecs[i].exp_xfers);
      rmode = 0;
      tick();
      tick();
    end

    // Capture window: bus changes right after the capture edge are ignored.
    load_pattern(16'h0A0B, 16'h0101);
    start_job(c0);
    wait_valid(c0, "capwin");
    mat_in = '1;
    wait_idle("capwin", NW);
    mat_in = '0;
    tick();

    // Overlap rejection: starts during WAIT and STREAM are dropped.
    load_pattern(16'h5000, 16'h0007);
    start_job(c0);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("drop_after_wait_start", 64'(drop_err), 64'd1);
    wait_valid(c0, "overlap");
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle("overlap", NW);
    chk("drop_sticky", 64'(drop_err), 64'd1);
    any_valid = 1'b0;
    repeat (8) begin
      @(negedge clk);
      any_valid = any_valid | m_valid;
    end
    chk("overlap_no_second_stream", 64'(any_valid), 64'd0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("drop_cleared_by_rst", 64'(drop_err), 64'd0);
    tick();

    // Back-to-back: start coincides with the final transfer.
    load_pattern(16'h0040, 16'h0100);
    start_job(c0);
    wait_valid(c0, "b2b_first");
    n = 0;
    while (!(m_valid && m_last) && n < 200) begin
      @(negedge clk);
      n++;
    end
    c1 = cyc;
    start = 1'b1;
    load_pattern(16'h8001, 16'h0202);
    push_expected();
    tick();
    start = 1'b0;
    for (int j = 1; j <= PL; j++) begin
      @(negedge clk);
      chk($sformatf("b2b_busy_gap%0d", j), 64'(busy), 64'd1);
      chk($sformatf("b2b_valid_gap%0d", j), 64'(m_valid), 64'd0);
    end
    @(negedge clk);
    chk("b2b_second_valid_cyc", 64'(cyc), 64'(c1 + PL + 1));
    wait_idle("b2b", 2 * NW);
    chk("b2b_no_drop", 64'(drop_err), 64'd0);
    tick();

    // Reset mid-stream after 10 transfers, with a start in the reset cycle.
    load_pattern(16'h3C00, 16'h0011);
    start_job(c0);
    wait_valid(c0, "rstmid");
    n = 0;
    while (job_xfers < 10 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rstmid_xfers_before", 64'(job_xfers), 64'd10);
    tick();
    rst   = 1'b1;
    start = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    sb.delete();
    @(negedge clk);
    chk_all_zero("rstmid_outputs_zero");
    any_valid = 1'b0;
    repeat (10) begin
      @(negedge clk);
      any_valid = any_valid | m_valid | busy;
    end
    chk("rstmid_no_more_valid", 64'(any_valid), 64'd0);
    tick();
    load_pattern(16'h0040, 16'h0100);
    start_job(c0);
    wait_valid(c0, "rstmid_fresh");
    wait_idle("rstmid_fresh", NW);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
